// File: rtl/weight_tile_loader.sv
// Weight tile loader: streams MUL_SIZE-row weight tiles from a FIFO into the
// systolic array shadow registers, waiting for a swap between tiles.
module weight_tile_loader #(
    parameter int unsigned MUL_SIZE = 32,
    parameter int unsigned W_WIDTH  = 7
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [15:0]                       num_tiles_i,
    input  logic                              fifo_valid_i,
    input  logic [MUL_SIZE*(W_WIDTH+1)-1:0]   fifo_data_i,
    output logic                              fifo_read_o,
    input  logic                              swap_i,
    output logic [MUL_SIZE*(W_WIDTH+1)-1:0]   weight_row_o,
    output logic                              weight_load_o,
    output logic [$clog2(MUL_SIZE)-1:0]       row_idx_o,
    output logic                              tile_ready_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int unsigned RowW = MUL_SIZE * (W_WIDTH + 1);
    localparam int unsigned IdxW = $clog2(MUL_SIZE);
    localparam logic [IdxW-1:0] LastRow = IdxW'(MUL_SIZE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitSwap,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       tiles_left_q, tiles_left_d;
    logic [IdxW-1:0]   row_cnt_q, row_cnt_d;
    logic [RowW-1:0]   row_q, row_d;
    logic              load_q, load_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              ready_q, ready_d;

    // State and datapath registers; reset discards any partially loaded tile.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            tiles_left_q <= '0;
            row_cnt_q    <= '0;
            row_q        <= '0;
            load_q       <= 1'b0;
            idx_q        <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tiles_left_q <= tiles_left_d;
            row_cnt_q    <= row_cnt_d;
            row_q        <= row_d;
            load_q       <= load_d;
            idx_q        <= idx_d;
            ready_q      <= ready_d;
        end
    end

    // Next-state logic: sequence rows within a tile and tiles within a request.
    always_comb begin
        state_d      = state_q;
        tiles_left_d = tiles_left_q;
        row_cnt_d    = row_cnt_q;
        row_d        = row_q;
        load_d       = 1'b0;
        idx_d        = idx_q;
        ready_d      = ready_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (num_tiles_i == '0) begin
                        state_d = StDone;
                    end else begin
                        tiles_left_d = num_tiles_i;
                        row_cnt_d    = '0;
                        state_d      = StLoad;
                    end
                end
            end
            StLoad: begin
                // fifo_read_o is high throughout LOAD, so valid alone accepts a row
                if (fifo_valid_i) begin
                    row_d  = fifo_data_i;
                    load_d = 1'b1;
                    idx_d  = row_cnt_q;
                    if (row_cnt_q == LastRow) begin
                        row_cnt_d = '0;
                        ready_d   = 1'b1;
                        state_d   = StWaitSwap;
                    end else begin
                        row_cnt_d = row_cnt_q + IdxW'(1);
                    end
                end
            end
            StWaitSwap: begin
                if (swap_i) begin
                    ready_d = 1'b0;
                    if (tiles_left_q != '0) begin
                        tiles_left_d = tiles_left_q - 16'd1;
                    end
                    state_d = (tiles_left_q <= 16'd1) ? StDone : StLoad;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: FIFO read and status flags decode straight from the state.
    always_comb begin
        fifo_read_o   = (state_q == StLoad);
        busy_o        = (state_q != StIdle);
        done_o        = (state_q == StDone);
        weight_row_o  = row_q;
        weight_load_o = load_q;
        row_idx_o     = idx_q;
        tile_ready_o  = ready_q;
    end

endmodule

// File: tb/tb_weight_tile_loader.sv
// Self-checking bench for weight_tile_loader: directed scenario table,
// randomized traffic against a transaction-level model, and mid-tile reset.
module tb_weight_tile_loader;

    localparam int unsigned MUL_SIZE = 32;
    localparam int unsigned W_WIDTH  = 7;
    localparam int unsigned DW       = MUL_SIZE * (W_WIDTH + 1);
    localparam int unsigned IdxW     = $clog2(MUL_SIZE);

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [15:0]     num_tiles_i;
    logic            fifo_valid_i;
    logic [DW-1:0]   fifo_data_i;
    logic            fifo_read_o;
    logic            swap_i;
    logic [DW-1:0]   weight_row_o;
    logic            weight_load_o;
    logic [IdxW-1:0] row_idx_o;
    logic            tile_ready_o;
    logic            busy_o;
    logic            done_o;

    weight_tile_loader #(
        .MUL_SIZE (MUL_SIZE),
        .W_WIDTH  (W_WIDTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .num_tiles_i   (num_tiles_i),
        .fifo_valid_i  (fifo_valid_i),
        .fifo_data_i   (fifo_data_i),
        .fifo_read_o   (fifo_read_o),
        .swap_i        (swap_i),
        .weight_row_o  (weight_row_o),
        .weight_load_o (weight_load_o),
        .row_idx_o     (row_idx_o),
        .tile_ready_o  (tile_ready_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: tiles still owed, rows delivered in the current tile,
    // a pending done pulse, and the last row delivered to the array.
    int            m_tiles;
    int            m_rows;
    bit            m_done;
    bit            m_load;
    logic [DW-1:0] m_row;
    int            m_idx;

    typedef struct {
        int n;
        bit tog;
        int sdly;
        bit spur;
        int loads;
        int reads;
        int readies;
        int dones;
    } scen_t;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_row();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DW / 32); i++) r = (r << 32) | DW'($urandom);
        return r;
    endfunction

    function automatic void model_reset();
        m_tiles = 0;
        m_rows  = 0;
        m_done  = 1'b0;
        m_load  = 1'b0;
        m_row   = '0;
        m_idx   = 0;
    endfunction

    function automatic void model_advance(input bit s, input int n, input bit v, input bit sw,
                                          input logic [DW-1:0] d);
        m_load = 1'b0;
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_tiles == 0) begin
            if (s) begin
                if (n == 0) m_done = 1'b1;
                else begin
                    m_tiles = n;
                    m_rows  = 0;
                end
            end
        end else if (m_rows < int'(MUL_SIZE)) begin
            if (v) begin
                m_row  = d;
                m_idx  = m_rows;
                m_load = 1'b1;
                m_rows++;
            end
        end else if (sw) begin
            m_tiles--;
            m_rows = 0;
            if (m_tiles == 0) m_done = 1'b1;
        end
    endfunction

    task automatic compare_all();
        bit active;
        active = (m_tiles != 0);
        check("fifo_read", DW'(fifo_read_o), DW'(active && m_rows < int'(MUL_SIZE)));
        check("tile_ready", DW'(tile_ready_o), DW'(active && m_rows == int'(MUL_SIZE)));
        check("busy", DW'(busy_o), DW'(active || m_done));
        check("done", DW'(done_o), DW'(m_done));
        check("weight_load", DW'(weight_load_o), DW'(m_load));
        check("weight_row", weight_row_o, m_row);
        if (m_load) check("row_idx", DW'(row_idx_o), DW'(m_idx));
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic step(input bit s, input int n, input bit v, input bit sw);
        logic [DW-1:0] d;
        d = rnd_row();
        start_i      = s;
        num_tiles_i  = 16'(n);
        fifo_valid_i = v;
        swap_i       = sw;
        fifo_data_i  = d;
        model_advance(s, n, v, sw, d);
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic run_seq(input scen_t sc, output int loads, output int reads,
                           output int readies, output int dones);
        int  age;
        bit  prev_ready;
        bit  s;
        bit  v;
        bit  sw;
        bit  spur_now;
        int  n;
        loads = 0; reads = 0; readies = 0; dones = 0;
        age = 0; prev_ready = 1'b0;
        for (int k = 0; k < 600; k++) begin
            spur_now = sc.spur && fifo_read_o && (k % 7 == 3);
            s  = (k == 0) || spur_now;
            n  = (k == 0) ? sc.n : 5;
            v  = sc.tog ? (k % 2 == 1) : 1'b1;
            sw = (tile_ready_o && age == sc.sdly) || spur_now;
            step(s, n, v, sw);
            loads += int'(weight_load_o);
            reads += int'(fifo_read_o);
            if (tile_ready_o && !prev_ready) readies++;
            prev_ready = tile_ready_o;
            age = tile_ready_o ? age + 1 : 0;
            if (done_o) begin
                dones++;
                break;
            end
        end
        // Done lasts a single cycle.
        step(1'b0, 0, 1'b0, 1'b0);
        check("done_single_cycle", DW'(done_o), DW'(0));
    endtask

    scen_t vec [5];

    initial begin
        int  loads, reads, readies, dones, age;
        bit  reached;

        vec[0] = '{n: 1, tog: 0, sdly: 1, spur: 0, loads: 32, reads: 32, readies: 1, dones: 1};
        vec[1] = '{n: 3, tog: 0, sdly: 6, spur: 0, loads: 96, reads: 96, readies: 3, dones: 1};
        vec[2] = '{n: 1, tog: 1, sdly: 1, spur: 0, loads: 32, reads: 63, readies: 1, dones: 1};
        vec[3] = '{n: 2, tog: 0, sdly: 3, spur: 1, loads: 64, reads: 64, readies: 2, dones: 1};
        vec[4] = '{n: 0, tog: 0, sdly: 1, spur: 0, loads: 0,  reads: 0,  readies: 0, dones: 1};

        rst_i = 1'b0; start_i = 1'b0; num_tiles_i = '0;
        fifo_valid_i = 1'b0; fifo_data_i = '0; swap_i = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk_i);
        rst_i = 1'b1;

        foreach (vec[i]) begin
            run_seq(vec[i], loads, reads, readies, dones);
            check($sformatf("vec%0d_loads", i), DW'(loads), DW'(vec[i].loads));
            check($sformatf("vec%0d_reads", i), DW'(reads), DW'(vec[i].reads));
            check($sformatf("vec%0d_readies", i), DW'(readies), DW'(vec[i].readies));
            check($sformatf("vec%0d_dones", i), DW'(dones), DW'(vec[i].dones));
        end

        // Random traffic: spurious starts and swaps everywhere, bursty FIFO.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 8) == 0, int'($urandom % 3), ($urandom % 4) != 0,
                 ($urandom % 4) == 0);
        end
        for (int k = 0; k < 300 && (m_tiles != 0 || m_done); k++) begin
            step(1'b0, 0, 1'b1, 1'b1);
        end

        // Reset at row 17 of the second tile of a 3-tile request.
        reached = 1'b0;
        age = 0;
        for (int k = 0; k < 400; k++) begin
            step(k == 0, 3, 1'b1, tile_ready_o && age == 2);
            age = tile_ready_o ? age + 1 : 0;
            if (m_tiles == 2 && m_load && m_idx == 17) begin
                reached = 1'b1;
                break;
            end
        end
        check("reset_point_reached", DW'(reached), DW'(1));
        rst_i = 1'b0;
        #1;
        check("rst_fifo_read", DW'(fifo_read_o), DW'(0));
        check("rst_weight_load", DW'(weight_load_o), DW'(0));
        check("rst_tile_ready", DW'(tile_ready_o), DW'(0));
        check("rst_busy", DW'(busy_o), DW'(0));
        check("rst_done", DW'(done_o), DW'(0));
        check("rst_weight_row", weight_row_o, DW'(0));
        check("rst_row_idx", DW'(row_idx_o), DW'(0));
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        run_seq(vec[0], loads, reads, readies, dones);
        check("post_rst_loads", DW'(loads), DW'(32));
        check("post_rst_dones", DW'(dones), DW'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
